// File: rtl/mul_shift_add_seq_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encodings and default sizes.
package mul_shift_add_seq_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add_seq_adder.sv
// Plain ripple-carry adder; the multiplier's only arithmetic unit.
module mul_shift_add_seq_adder
    import mul_shift_add_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // NOTE: every output gets a value on every pass through the block, so no latch is inferred.
    always_comb begin
        logic carry;
        carry = 1'b0;
        sum_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/mul_shift_add_seq.sv
// Sequential 32x32 -> 64 unsigned shift-and-add multiplier with start/done handshake.
// Optional early termination on exhausted multiplier bits: define MUL_EARLY_TERM_EN.
module mul_shift_add_seq
    import mul_shift_add_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    if (WIDTH != MUL_WIDTH || CNT_W < $clog2(WIDTH + 1)) begin : g_param_check
        $error("mul_shift_add_seq: WIDTH must be 32 and CNT_W must hold WIDTH");
    end

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   add_s;
    logic               add_c;

    assign addend = lo_q[0] ? m_q : '0;

    mul_shift_add_seq_adder #(.WIDTH(WIDTH)) u_adder (
        .a_i    (hi_q),
        .b_i    (addend),
        .sum_o  (add_s),
        .cout_o (add_c)
    );

`ifdef MUL_EARLY_TERM_EN
    // lo_q[cnt_q:1] are the multiplier bits still waiting after this cycle's add.
    logic [WIDTH-2:0] rem_mask;
    logic             rem_zero;
    assign rem_mask = ~({(WIDTH-1){1'b1}} << cnt_q);
    assign rem_zero = ((lo_q[WIDTH-1:1] & rem_mask) == '0);
`endif

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    m_d     = A;
                    hi_d    = '0;
                    lo_d    = B;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = MUL_RUN;
                end
            end
            MUL_RUN: begin
                // 65-bit shift of {carry, sum, LO}: the carry-out becomes HI's new MSB.
                hi_d  = {add_c, add_s[WIDTH-1:1]};
                lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    p_d     = {hi_d, lo_d};
                    state_d = MUL_DONE;
                end
`ifdef MUL_EARLY_TERM_EN
                else if (rem_zero) begin
                    // Remaining steps would add zero; collapse their shifts into one.
                    p_d     = {hi_d, lo_d} >> cnt_q;
                    state_d = MUL_DONE;
                end
`endif
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign ready = (state_q == MUL_IDLE);
    assign busy  = (state_q == MUL_RUN);
    assign done  = (state_q == MUL_DONE);
    assign P     = p_q;

endmodule
